// File: rtl/fir_host_pkg.sv
// rtl/fir_host_pkg.sv - shared state type and size defaults for the FIR host controller
package fir_host_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_NUM_COEFFS = 4;

  typedef enum logic [2:0] {
    IDLE,
    COEFF_PULSE,
    COEFF_WAIT,
    SAMPLE_REQ,
    SAMPLE_WAIT,
    CAPTURE,
    FAULT
  } state_t;

endpackage

// File: rtl/handshake_timer.sv
// rtl/handshake_timer.sv - saturating cycle counter that flags a stalled handshake
module handshake_timer #(
  parameter int TIMEOUT = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_cnt;

  // Count enabled cycles; clear dominates and the count never wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Terminal count is hit on the TIMEOUT-th enabled cycle
  assign o_tc = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fir_host_ctrl.sv
// rtl/fir_host_ctrl.sv - host-side sequencer feeding coefficients and samples to a FIR filter
module fir_host_ctrl
  import fir_host_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_COEFFS = DEF_NUM_COEFFS,
  parameter int LC_PULSE   = 2,
  parameter int TIMEOUT    = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] coeff_in,
  input  logic              coeff_valid,
  output logic              coeff_ready,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [DATA_W-1:0] fir_coefficient,
  output logic              load_coeff,
  output logic [DATA_W-1:0] sample_data,
  output logic              data_ready,
  input  logic              modwait,
  input  logic [DATA_W-1:0] fir_out,
  input  logic              err,
  output logic [DATA_W-1:0] result_data,
  output logic              result_err,
  output logic              result_valid,
  output logic              coeff_loaded,
  output logic              timeout
);

  localparam int IDX_W = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;
  localparam int PC_W  = (LC_PULSE > 1) ? $clog2(LC_PULSE) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [PC_W-1:0]   r_pcnt;
  logic              r_seen_busy;
  logic              r_coeff_loaded;
  logic [DATA_W-1:0] r_fir_coefficient;
  logic [DATA_W-1:0] r_sample_data;
  logic [DATA_W-1:0] r_result_data;
  logic              r_result_err;
  logic              r_result_valid;
  logic              w_coeff_hs;
  logic              w_sample_hs;
  logic              w_coeff_done;
  logic              w_capture;
  logic              w_tc;
  logic              w_timer_clr;
  logic              w_timer_en;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and handshake outputs; a stalled handshake always lands in FAULT
  always_comb begin
    w_next       = r_state;
    w_coeff_hs   = 1'b0;
    w_sample_hs  = 1'b0;
    w_coeff_done = 1'b0;
    w_capture    = 1'b0;
    coeff_ready  = 1'b0;
    sample_ready = 1'b0;
    load_coeff   = 1'b0;
    data_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        coeff_ready  = 1'b1;
        sample_ready = r_coeff_loaded & ~coeff_valid;
        if (coeff_valid) begin
          w_coeff_hs = 1'b1;
          w_next     = COEFF_PULSE;
        end else if (sample_valid && r_coeff_loaded) begin
          w_sample_hs = 1'b1;
          w_next      = SAMPLE_REQ;
        end
      end
      COEFF_PULSE: begin
        load_coeff = 1'b1;
        if (r_pcnt == PC_W'(LC_PULSE - 1)) w_next = COEFF_WAIT;
      end
      COEFF_WAIT: begin
        if (r_seen_busy && !modwait) begin
          w_coeff_done = 1'b1;
          w_next       = IDLE;
        end
      end
      SAMPLE_REQ: begin
        data_ready = 1'b1;
        if (modwait) w_next = SAMPLE_WAIT;
      end
      SAMPLE_WAIT: begin
        if (!modwait) w_next = CAPTURE;
      end
      CAPTURE: begin
        w_capture = 1'b1;
        w_next    = IDLE;
      end
      FAULT: begin
        w_next = FAULT;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (w_tc) begin
      w_next       = FAULT;
      w_coeff_done = 1'b0;
      w_capture    = 1'b0;
    end
    // Ready is decoded from IDLE, which reset also selects, so mask it while reset is held
    if (reset) begin
      coeff_ready  = 1'b0;
      sample_ready = 1'b0;
    end
  end

  // Coefficient path: latch, pulse length, filter-busy tracking, index and full-set flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fir_coefficient <= '0;
      r_pcnt            <= '0;
      r_seen_busy       <= 1'b0;
      r_idx             <= '0;
      r_coeff_loaded    <= 1'b0;
    end else begin
      if (r_state == COEFF_PULSE) r_pcnt <= r_pcnt + 1'b1;
      else                        r_pcnt <= '0;
      if (r_state == IDLE) begin
        r_seen_busy <= 1'b0;
      end else if (modwait && (r_state == COEFF_PULSE || r_state == COEFF_WAIT)) begin
        r_seen_busy <= 1'b1;
      end
      if (w_coeff_hs) begin
        r_fir_coefficient <= coeff_in;
        if (r_coeff_loaded) begin
          r_coeff_loaded <= 1'b0;
          r_idx          <= '0;
        end
      end
      if (w_coeff_done) begin
        if (r_idx == IDX_W'(NUM_COEFFS - 1)) begin
          r_idx          <= '0;
          r_coeff_loaded <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  // Sample latch and one-shot result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample_data  <= '0;
      r_result_data  <= '0;
      r_result_err   <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      if (w_sample_hs) r_sample_data <= sample_in;
      r_result_valid <= w_capture;
      if (w_capture) begin
        r_result_data <= fir_out;
        r_result_err  <= err;
      end
    end
  end

  assign w_timer_clr = (r_state == IDLE);
  assign w_timer_en  = (r_state != IDLE) && (r_state != FAULT);

  handshake_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_timer_clr),
    .i_enable(w_timer_en),
    .o_tc    (w_tc)
  );

  assign fir_coefficient = r_fir_coefficient;
  assign sample_data     = r_sample_data;
  assign result_data     = r_result_data;
  assign result_err      = r_result_err;
  assign result_valid    = r_result_valid;
  assign coeff_loaded    = r_coeff_loaded;
  assign timeout         = (r_state == FAULT);

endmodule

// File: tb/tb_fir_host_ctrl.sv
// tb/tb_fir_host_ctrl.sv - scenario bench for fir_host_ctrl with a modwait responder
module tb_fir_host_ctrl;

  localparam int DATA_W     = 16;
  localparam int NUM_COEFFS = 4;
  localparam int LC_PULSE   = 2;
  localparam int TIMEOUT    = 25;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] coeff_in = '0;
  logic              coeff_valid = 1'b0;
  logic              coeff_ready;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              sample_ready;
  logic [DATA_W-1:0] fir_coefficient;
  logic              load_coeff;
  logic [DATA_W-1:0] sample_data;
  logic              data_ready;
  logic              modwait;
  logic [DATA_W-1:0] fir_out = '0;
  logic              err = 1'b0;
  logic [DATA_W-1:0] result_data;
  logic              result_err;
  logic              result_valid;
  logic              coeff_loaded;
  logic              timeout;

  int checks = 0;
  int errors = 0;
  int rv_count = 0;
  int lc_cycles = 0;
  int both_cnt = 0;
  bit resp_en = 1'b0;

  logic [DATA_W-1:0] coeff_tab [NUM_COEFFS];
  logic [DATA_W-1:0] coeff_q [$];
  logic [DATA_W:0]   result_q [$];

  fir_host_ctrl #(
    .DATA_W(DATA_W), .NUM_COEFFS(NUM_COEFFS), .LC_PULSE(LC_PULSE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .coeff_in(coeff_in), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .fir_coefficient(fir_coefficient), .load_coeff(load_coeff),
    .sample_data(sample_data), .data_ready(data_ready),
    .modwait(modwait), .fir_out(fir_out), .err(err),
    .result_data(result_data), .result_err(result_err), .result_valid(result_valid),
    .coeff_loaded(coeff_loaded), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Cycle-level monitors: pulse counts and load/data exclusivity
  always @(posedge clk) begin
    if (result_valid) rv_count <= rv_count + 1;
    if (load_coeff) lc_cycles <= lc_cycles + 1;
    if (load_coeff && data_ready) both_cnt <= both_cnt + 1;
  end

  // Filter model: raise modwait 2 cycles after a load/data request, hold it 2 cycles
  initial begin : responder
    int rcnt;
    rcnt = -1;
    modwait = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        modwait = 1'b0;
        rcnt = -1;
      end else if (rcnt >= 0) begin
        rcnt++;
        if (rcnt == 2) modwait = 1'b1;
        else if (rcnt == 4) begin
          modwait = 1'b0;
          rcnt = -1;
        end
      end else if (resp_en && (load_coeff || data_ready)) begin
        rcnt = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200us, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({coeff_ready, sample_ready, load_coeff, data_ready, result_valid, result_err, coeff_loaded, timeout} !== 8'b0
        || fir_coefficient !== '0 || sample_data !== '0 || result_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b coef=%h samp=%h res=%h, required all zero",
               {coeff_ready, sample_ready, load_coeff, data_ready, result_valid, result_err, coeff_loaded, timeout},
               fir_coefficient, sample_data, result_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (coeff_ready !== 1'b1 || sample_ready !== 1'b0 || coeff_loaded !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: coeff_ready=%b sample_ready=%b coeff_loaded=%b, required 1/0/0",
               coeff_ready, sample_ready, coeff_loaded);
    end
  endtask

  task automatic test_sample_before_load();
    int dr;
    int sr;
    dr = 0;
    sr = 0;
    sample_in = 16'h1234;
    sample_valid = 1'b1;
    #1;
    repeat (6) begin
      if (sample_ready) sr++;
      if (data_ready) dr++;
      tick();
    end
    sample_valid = 1'b0;
    checks++;
    if (sr != 0 || dr != 0 || coeff_ready !== 1'b1) begin
      errors++;
      $display("FAIL sample_before_load: sample_ready cycles=%0d data_ready cycles=%0d coeff_ready=%b, required 0/0/1",
               sr, dr, coeff_ready);
    end
  endtask

  task automatic test_coeff_load(input int first, input int n);
    int lc0;
    int waited;
    logic [DATA_W-1:0] exp_c;
    resp_en = 1'b1;
    for (int i = first; i < first + n; i++) begin
      coeff_q.push_back(coeff_tab[i]);
      lc0 = lc_cycles;
      coeff_in = coeff_tab[i];
      coeff_valid = 1'b1;
      tick();
      coeff_valid = 1'b0;
      coeff_in = '0;
      exp_c = coeff_q.pop_front();
      checks++;
      if (load_coeff !== 1'b1 || fir_coefficient !== exp_c) begin
        errors++;
        $display("FAIL coeff_latch[%0d]: load_coeff=%b fir_coefficient=%h, required 1/%h",
                 i, load_coeff, fir_coefficient, exp_c);
      end
      waited = 0;
      while (coeff_ready !== 1'b1 && waited < 40) begin
        tick();
        waited++;
      end
      checks++;
      if (waited >= 40) begin
        errors++;
        $display("FAIL coeff_done[%0d]: no return to IDLE within %0d cycles, required completion", i, waited);
      end
      checks++;
      if (lc_cycles - lc0 != LC_PULSE) begin
        errors++;
        $display("FAIL coeff_pulse_len[%0d]: load_coeff high %0d cycles, required %0d", i, lc_cycles - lc0, LC_PULSE);
      end
      checks++;
      if (coeff_loaded !== (i == NUM_COEFFS - 1)) begin
        errors++;
        $display("FAIL coeff_loaded[%0d]: got %b, required %b", i, coeff_loaded, (i == NUM_COEFFS - 1));
      end
    end
  endtask

  task automatic test_sample(input logic [DATA_W-1:0] val, input logic [DATA_W-1:0] fir,
                             input logic e);
    int rv0;
    int waited;
    bit rise_seen;
    bit after_done;
    logic dr_at_rise;
    logic dr_after;
    logic [DATA_W:0] exp_r;
    resp_en = 1'b1;
    fir_out = fir;
    err = e;
    result_q.push_back({e, fir});
    rv0 = rv_count;
    sample_in = val;
    sample_valid = 1'b1;
    #1;
    waited = 0;
    while (sample_ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    tick();
    sample_valid = 1'b0;
    checks++;
    if (data_ready !== 1'b1 || sample_data !== val) begin
      errors++;
      $display("FAIL sample_latch: data_ready=%b sample_data=%h, required 1/%h", data_ready, sample_data, val);
    end
    rise_seen = 0;
    after_done = 0;
    dr_at_rise = 1'b0;
    dr_after = 1'b1;
    waited = 0;
    while (result_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      #1;
      if (modwait && !rise_seen) begin
        rise_seen = 1;
        dr_at_rise = data_ready;
      end
      tick();
      waited++;
      if (rise_seen && !after_done) begin
        after_done = 1;
        dr_after = data_ready;
      end
    end
    checks++;
    if (dr_at_rise !== 1'b1 || dr_after !== 1'b0) begin
      errors++;
      $display("FAIL data_ready_drop: at modwait rise=%b next cycle=%b, required 1/0", dr_at_rise, dr_after);
    end
    checks++;
    if (waited >= 40) begin
      errors++;
      $display("FAIL result_wait: no result_valid within %0d cycles, required a pulse", waited);
    end else begin
      exp_r = result_q.pop_front();
      checks++;
      if ({result_err, result_data} !== exp_r) begin
        errors++;
        $display("FAIL result_value: err=%b data=%h, required err=%b data=%h",
                 result_err, result_data, exp_r[DATA_W], exp_r[DATA_W-1:0]);
      end
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || rv_count - rv0 != 1 || result_data !== fir || result_err !== e) begin
      errors++;
      $display("FAIL result_pulse: result_valid=%b pulses=%0d held=%h/%b, required 0/1/%h/%b",
               result_valid, rv_count - rv0, result_data, result_err, fir, e);
    end
  endtask

  task automatic test_priority();
    int waited;
    int dr;
    resp_en = 1'b1;
    coeff_in = coeff_tab[0];
    coeff_valid = 1'b1;
    sample_in = 16'h0BAD;
    sample_valid = 1'b1;
    #1;
    checks++;
    if (sample_ready !== 1'b0 || coeff_ready !== 1'b1) begin
      errors++;
      $display("FAIL prio_ready: sample_ready=%b coeff_ready=%b, required 0/1", sample_ready, coeff_ready);
    end
    tick();
    coeff_valid = 1'b0;
    checks++;
    if (load_coeff !== 1'b1 || data_ready !== 1'b0 || fir_coefficient !== coeff_tab[0] || coeff_loaded !== 1'b0) begin
      errors++;
      $display("FAIL prio_accept: load_coeff=%b data_ready=%b coef=%h coeff_loaded=%b, required 1/0/%h/0",
               load_coeff, data_ready, fir_coefficient, coeff_tab[0], coeff_loaded);
    end
    waited = 0;
    dr = 0;
    while (coeff_ready !== 1'b1 && waited < 40) begin
      tick();
      waited++;
      if (data_ready) dr++;
    end
    repeat (3) begin
      tick();
      if (data_ready) dr++;
    end
    sample_valid = 1'b0;
    checks++;
    if (waited >= 40 || dr != 0 || coeff_loaded !== 1'b0) begin
      errors++;
      $display("FAIL prio_after: waited=%0d data_ready cycles=%0d coeff_loaded=%b, required <40/0/0",
               waited, dr, coeff_loaded);
    end
    test_coeff_load(1, NUM_COEFFS - 1);
  endtask

  task automatic test_reset_mid_sample();
    int rv0;
    int waited;
    resp_en = 1'b1;
    rv0 = rv_count;
    fir_out = 16'h1111;
    err = 1'b1;
    sample_in = 16'h2222;
    sample_valid = 1'b1;
    #1;
    waited = 0;
    while (sample_ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    tick();
    sample_valid = 1'b0;
    waited = 0;
    while (!(modwait === 1'b1 && data_ready === 1'b0) && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL mid_reach_wait: SAMPLE_WAIT not observed within %0d cycles, required entry", waited);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({coeff_ready, sample_ready, load_coeff, data_ready, result_valid, result_err, coeff_loaded, timeout} !== 8'b0
        || fir_coefficient !== '0 || sample_data !== '0 || result_data !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: flags=%b coef=%h samp=%h res=%h, required all zero",
               {coeff_ready, sample_ready, load_coeff, data_ready, result_valid, result_err, coeff_loaded, timeout},
               fir_coefficient, sample_data, result_data);
    end
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    checks++;
    if (rv_count != rv0 || result_valid !== 1'b0 || coeff_loaded !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_abort: pulses=%0d result_valid=%b coeff_loaded=%b, required 0/0/0",
               rv_count - rv0, result_valid, coeff_loaded);
    end
  endtask

  task automatic test_timeout();
    resp_en = 1'b0;
    coeff_in = 16'h1357;
    coeff_valid = 1'b1;
    sample_valid = 1'b1;
    tick();
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: timeout=%b after %0d cycles, required 0", timeout, TIMEOUT - 1);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || {load_coeff, data_ready, coeff_ready, sample_ready} !== 4'b0) begin
      errors++;
      $display("FAIL timeout_fault: timeout=%b lc/dr/cr/sr=%b, required 1/0000",
               timeout, {load_coeff, data_ready, coeff_ready, sample_ready});
    end
    repeat (5) tick();
    checks++;
    if (timeout !== 1'b1 || coeff_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: timeout=%b coeff_ready=%b, required 1/0", timeout, coeff_ready);
    end
    coeff_valid = 1'b0;
    sample_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_reset: timeout=%b under reset, required 0", timeout);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (timeout !== 1'b0 || coeff_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover: timeout=%b coeff_ready=%b, required 0/1", timeout, coeff_ready);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL load_data_exclusive: %0d cycles with both high, required 0", both_cnt);
    end
  endtask

  initial begin : main
    coeff_tab = '{16'h4000, 16'h8000, 16'h8000, 16'h4000};
    test_reset();
    test_sample_before_load();
    test_coeff_load(0, NUM_COEFFS);
    test_sample(16'd100, 16'd50, 1'b0);
    test_sample(16'hFFFF, 16'h7FFF, 1'b1);
    test_sample(16'h0A5A, 16'h1234, 1'b0);
    test_priority();
    test_sample(16'h0042, 16'hBEEF, 1'b1);
    test_reset_mid_sample();
    test_timeout();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
